// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial full adder built as a 4-state Moore FSM.
// One bit of each operand is consumed per clock, LSB first. The state is
// {carry,sum} of the most recent addition, so the outputs are the state bits.
// Optional word framing is enabled with the macro SERIAL_ADDER_WORD_FRAME_EN:
// a bit counter marks the MSB of each WORD_LEN-bit word, raises word_done
// alongside the MSB result and clears the carry-in for the next word.
module serial_adder_fsm
`ifdef SERIAL_ADDER_WORD_FRAME_EN
#(
  parameter int WORD_LEN = 8
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
`ifdef SERIAL_ADDER_WORD_FRAME_EN
  ,
  output logic word_done
`endif
);

  // State encoding is {carry,sum}; every encoding is reachable and legal.
  typedef enum logic [1:0] {
    S_C0_S0 = 2'b00,
    S_C0_S1 = 2'b01,
    S_C1_S0 = 2'b10,
    S_C1_S1 = 2'b11
  } state_t;

  state_t     r_state;
  logic       w_cin;
  logic [1:0] w_total;

`ifdef SERIAL_ADDER_WORD_FRAME_EN
  localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_word_done;
  logic             w_msb;

  // The bit after an MSB starts a fresh word, so its carry-in reads as 0
  // even though the carry output still shows the MSB's true carry-out.
  assign w_cin = r_state[1] & ~r_word_done;
  assign w_msb = (r_cnt == CNT_LAST);
`else
  // Unframed: the carry runs on until the user separates words with reset.
  assign w_cin = r_state[1];
`endif

  // Two-bit total of the three addend bits: {carry-out, sum}.
  assign w_total = {1'b0, a} + {1'b0, b} + {1'b0, w_cin};

  // FSM: reset wins over operands and any in-flight carry; otherwise the
  // next state is the full-adder result of this cycle's bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_C0_S0;
`ifdef SERIAL_ADDER_WORD_FRAME_EN
      r_cnt       <= '0;
      r_word_done <= 1'b0;
`endif
    end else begin
      case ({w_total[1], w_total[0]})
        2'b00:   r_state <= S_C0_S0;
        2'b01:   r_state <= S_C0_S1;
        2'b10:   r_state <= S_C1_S0;
        default: r_state <= S_C1_S1;
      endcase
`ifdef SERIAL_ADDER_WORD_FRAME_EN
      r_word_done <= w_msb;
      r_cnt       <= w_msb ? '0 : r_cnt + 1'b1;
`endif
    end
  end

  // Moore outputs come straight from the state register.
  assign sum   = r_state[0];
  assign carry = r_state[1];
`ifdef SERIAL_ADDER_WORD_FRAME_EN
  assign word_done = r_word_done;
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: self-checking bench for serial_adder_fsm.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Observations are packed as {word_done, carry, sum}, with
// word_done read as 0 in the unframed build.
module tb_serial_adder_fsm;

`ifdef SERIAL_ADDER_WORD_FRAME_EN
  localparam int WL = 4;
`else
  localparam int WL = 0;  // 0 means no framing in the reference model
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic sum;
  logic carry;
  logic word_done_obs;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  // Reference model: carry into the next bit and bit position within a word.
  int m_cin = 0;
  int m_pos = 0;

`ifdef SERIAL_ADDER_WORD_FRAME_EN
  logic word_done;
  serial_adder_fsm #(.WORD_LEN(WL)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .sum(sum), .carry(carry), .word_done(word_done)
  );
  assign word_done_obs = word_done;
`else
  serial_adder_fsm dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .sum(sum), .carry(carry)
  );
  assign word_done_obs = 1'b0;
`endif

  // Clock
  always #5 clk = ~clk;

  // Model one clock: returns the expected {word_done, carry, sum} after it.
  function automatic logic [2:0] model_step(input logic ia, input logic ib, input logic ir);
    int t;
    logic done;
    if (ir) begin
      m_cin = 0;
      m_pos = 0;
      return 3'b000;
    end
    t = int'(ia) + int'(ib) + m_cin;
    done = 1'b0;
    m_cin = t / 2;
    if (WL != 0) begin
      m_pos = m_pos + 1;
      if (m_pos == WL) begin
        m_pos = 0;
        done = 1'b1;
        m_cin = 0;
      end
    end
    return {done, 1'(t / 2), 1'(t % 2)};
  endfunction

  // Drive one cycle of inputs and return the sampled outputs.
  task automatic step(input logic ia, input logic ib, input logic ir, output logic [2:0] got);
    @(negedge clk);
    a = ia;
    b = ib;
    reset = ir;
    @(posedge clk);
    #1;
    got = {word_done_obs, carry, sum};
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got{done,c,s}=%b expected=%b", name, got, exp);
    end
  endtask

  // Step plus a check against the reference model.
  task automatic step_chk(input string name, input logic ia, input logic ib, input logic ir,
                          output logic [2:0] got);
    logic [2:0] e;
    e = model_step(ia, ib, ir);
    step(ia, ib, ir, got);
    chk(name, got, e);
  endtask

  // Reset for one cycle, then stream an n-bit word; return assembled sum and last carry.
  task automatic add_word(input logic [63:0] wa, input logic [63:0] wb, input int n,
                          output logic [63:0] s, output logic c);
    logic [2:0] g;
    step_chk("word_reset", 1'b0, 1'b0, 1'b1, g);
    s = '0;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      step_chk("word_bit", wa[i], wb[i], 1'b0, g);
      s[i] = g[0];
      c = g[1];
    end
  endtask

  typedef struct {
    logic       va;
    logic       vb;
    logic       vr;
    logic [1:0] exp_cs;  // {carry, sum}
  } vec_t;

  vec_t tbl[11];
  logic [2:0] g;
  logic [63:0] s;
  logic c;

  initial begin
    // Reset: held two cycles with a=b=1, then the first real addition.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 2'b00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b00};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b10};
    // Truth-table sequence from reset.
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b00};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'b10};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b01};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b01};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'b01};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'b10};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b10};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b10};

`ifndef SERIAL_ADDER_WORD_FRAME_EN
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].va, tbl[i].vb, tbl[i].vr, g);
      chk($sformatf("table[%0d]", i), g, {1'b0, tbl[i].exp_cs});
    end
    step(1'b1, 1'b1, 1'b0, g);
    chk("table_tail_11", g, 3'b011);
    step(1'b0, 1'b0, 1'b0, g);
    chk("table_tail_00", g, 3'b001);

    // 8-bit word 0x5A + 0x3C.
    add_word(64'h5A, 64'h3C, 8, s, c);
    chk("word_5a_3c_sum", s[2:0], 3'(8'h96));
    total++;
    if (s[7:0] !== 8'h96 || c !== 1'b0) begin
      bad++;
      $display("FAIL word_5a_3c got sum=%h carry=%b expected sum=96 carry=0", s[7:0], c);
    end

    // Overflow 0xFF + 0x01, then one more zero bit shows the carry out.
    add_word(64'hFF, 64'h01, 8, s, c);
    total++;
    if (s[7:0] !== 8'h00 || c !== 1'b1) begin
      bad++;
      $display("FAIL overflow got sum=%h carry=%b expected sum=00 carry=1", s[7:0], c);
    end
    step_chk("overflow_next", 1'b0, 1'b0, 1'b0, g);
    chk("overflow_next_fixed", g, 3'b001);
`else
    // Reset portion of the table is framing-independent.
    for (int i = 0; i < 3; i++) begin
      step(tbl[i].va, tbl[i].vb, tbl[i].vr, g);
      chk($sformatf("table[%0d]", i), g, {1'b0, tbl[i].exp_cs});
    end

    // Framing: 0xF + 0x1 twice back to back with WORD_LEN=4.
    step_chk("frame_reset", 1'b0, 1'b0, 1'b1, g);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < WL; i++) begin
        step_chk("frame_bit", 1'b1, (i == 0), 1'b0, g);
        if (i == 0) chk("frame_first_bit", g, 3'b010);
        if (i == WL - 1) chk("frame_msb", g, 3'b110);
      end
    end
    step_chk("frame_after", 1'b0, 1'b0, 1'b0, g);
    chk("frame_after_fixed", g, 3'b000);
`endif

    // Reset mid-stream from S_C1_S1.
    step_chk("mid_reset0", 1'b0, 1'b0, 1'b1, g);
    step_chk("mid_c1s0", 1'b1, 1'b1, 1'b0, g);
    step_chk("mid_c1s1", 1'b1, 1'b1, 1'b0, g);
    chk("mid_in_c1s1", g, 3'b011);
    step_chk("mid_reset", 1'b1, 1'b1, 1'b1, g);
    chk("mid_reset_fixed", g, 3'b000);
    step_chk("mid_release", 1'b1, 1'b0, 1'b0, g);
    chk("mid_release_fixed", g, 3'b001);

    // Randomised whole words checked against integer addition.
`ifndef SERIAL_ADDER_WORD_FRAME_EN
    for (int k = 0; k < 20; k++) begin
      logic [63:0] ra, rb;
      logic [8:0] ref_sum;
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      ref_sum = {1'b0, ra[7:0]} + {1'b0, rb[7:0]};
      add_word(ra, rb, 8, s, c);
      total++;
      if ({c, s[7:0]} !== ref_sum) begin
        bad++;
        $display("FAIL rand_word a=%h b=%h got=%h expected=%h", ra[7:0], rb[7:0], {c, s[7:0]}, ref_sum);
      end
    end
`endif

    // Randomised bit stream with occasional reset, through the scoreboard.
    for (int k = 0; k < 400; k++) begin
      logic ra, rb, rr;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 19) == 0);
      exp_q.push_back(model_step(ra, rb, rr));
      step(ra, rb, rr, g);
      chk("rand_stream", g, exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
- Bit-serial full adder implemented as a 4-state Moore FSM.
- Each clock it consumes one bit of each operand (a, b), LSB first.
- The running carry is held in state; registered sum and carry bits are presented the following cycle.
- Used as a low-area adder in serial datapaths where operands stream one bit per clock.

Parameters:
- WORD_LEN, 8, operand length in bits; used only when SERIAL_ADDER_WORD_FRAME_EN is defined (range 2..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  1  operand A bit for this cycle, LSB first.
- b  input  1  operand B bit for this cycle, LSB first.
- sum  output  1  registered sum bit of the previous cycle's addition.
- carry  output  1  registered carry-out of the previous cycle's addition; also the carry-in for the current cycle.
- word_done  output  1  present only with SERIAL_ADDER_WORD_FRAME_EN; see Optional Feature.

Behaviour:
- One clock, clk. Reset is synchronous and active-high; reset is sampled on the rising clk edge.
- States, encoded {carry,sum}:
  - S_C0_S0 = 2'b00
  - S_C0_S1 = 2'b01
  - S_C1_S0 = 2'b10
  - S_C1_S1 = 2'b11
- Outputs decode directly from the state register (Moore): sum = state[0], carry = state[1]. No combinational path from a/b to the outputs.
- Reset:
  - Reset high at a rising edge gives state = S_C0_S0, so sum = 0 and carry = 0.
  - Reset has priority over a/b, and over any in-flight addition (reset mid-stream discards the carry).
- Transition, reset low: let t = a + b + state[1] (0..3). Next state = {t[1], t[0]}. So:
  - From C0 states: a=b=0 goes to S_C0_S0; exactly one of a,b high goes to S_C0_S1; a=b=1 goes to S_C1_S0.
  - From C1 states: a=b=0 goes to S_C0_S1; exactly one high goes to S_C1_S0; a=b=1 goes to S_C1_S1.
- Latency: inputs sampled at edge N appear on sum/carry after edge N (valid throughout cycle N+1).
- Inputs must be stable around the rising edge. The testing convention is to change them mid-low-phase.
- Without the optional feature, carry propagates indefinitely. The first bit after reset sees carry-in 0. The user separates words by asserting reset for one cycle.
- The state register is the only storage. All four encodings are legal, so there is no illegal-state recovery.

Optional Feature:
- Macro SERIAL_ADDER_WORD_FRAME_EN.
- When defined:
  - Adds a bit counter of width clog2(WORD_LEN), cleared by reset, incrementing each non-reset cycle and wrapping from WORD_LEN-1 to 0.
  - On the cycle the counter equals WORD_LEN-1, the carry-in used for the next word is forced to 0. Formally, next state = {t[1], t[0]}, and the following cycle's carry-in reads as 0 (the carry output still shows the true carry-out of the MSB).
  - word_done is registered high for the one cycle in which sum/carry carry the MSB result, and is 0 at reset.
- When undefined: no counter, no word_done port, and the behaviour is exactly as above.

Test Plan:
- Reset: hold reset 2 cycles with a=b=1 -> sum=0, carry=0 throughout; the first post-reset result is sum=0 and carry=1 for a=b=1.
- Truth table: from reset, apply (a,b) = (1,1),(0,0),(0,1),(1,0),(1,1),(0,1),(1,0),(1,1),(0,0), one per cycle. Expected (sum,carry) one cycle later for each: (0,1),(1,0),(1,0),(1,0),(0,1),(0,1),(0,1),(1,1),(1,0).
- 8-bit word: stream A=0x5A and B=0x3C LSB first after reset -> sum bits assemble to 0x96; carry after the MSB = 0.
- Overflow: stream A=0xFF and B=0x01 -> sum bits 0x00; carry=1 after the MSB. Then a=b=0 for one more cycle -> sum=1, carry=0.
- Reset mid-stream: in state S_C1_S1, assert reset with a=b=1 -> next cycle sum=0, carry=0. Then deassert with a=1, b=0 -> sum=1, carry=0.
- Framing (macro on, WORD_LEN=4): stream A=0xF and B=0x1 twice back-to-back.
  - After each MSB: carry=1 and word_done=1.
  - First bit of the second word sees carry-in 0: its sum = 0 and carry = 1 (1+1).
